// File: rtl/main_fsm.sv
// main_fsm: multicycle main controller for the ARM core.
// Walks each instruction through fetch / decode / execute / memory /
// writeback and drives the shared-memory multicycle datapath. Memory
// states wait on mem_ready. A stall counter forces a sticky FAULT state
// when WAIT_LIMIT consecutive stalls are exceeded (WAIT_LIMIT = 0 turns
// the timeout off).
// Optional feature: define MAIN_FSM_BL_EN to enable branch-with-link
// (link_w pulses in BRANCH when link=1). Without it link_w is tied to 0.
module main_fsm #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic       funct_5,
   input  logic       funct_0,
   input  logic       link,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       ir_w,
   output logic       pc_w,
   output logic       branch,
   output logic       reg_w,
   output logic       mem_w,
   output logic       link_w,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       alu_op,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic       fault,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_FAULT  = 4'd10;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
   localparam bit               TIMEOUT_EN = (WAIT_LIMIT != 0);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_state;
   logic             wait_hit;

   // Memory-waiting states, and the stall that would exceed the limit.
   always_comb begin
      mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
      wait_hit  = TIMEOUT_EN && (cnt_q == CNT_LIMIT) && !mem_ready;
   end

   // Next-state logic; mem_ready always wins over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)     state_d = S_DECODE;
            else if (wait_hit) state_d = S_FAULT;
         end
         S_DECODE: begin
            case (op)
               2'b00:   state_d = funct_5 ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FAULT;
            endcase
         end
         S_MEMADR: state_d = funct_0 ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem_ready)     state_d = S_MEMWB;
            else if (wait_hit) state_d = S_FAULT;
         end
         S_MEMWR: begin
            if (mem_ready)     state_d = S_FETCH;
            else if (wait_hit) state_d = S_FAULT;
         end
         S_MEMWB:  state_d = S_FETCH;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FAULT;
      endcase
   end

   // Stall counter: restarts on any state change, counts saturating stalls.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (mem_state && !mem_ready && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifndef MAIN_FSM_BL_EN
   logic unused_link;
   assign unused_link = link;
`endif

   // Per-state datapath controls; write enables and mem_req are masked during reset.
   always_comb begin
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      ir_w       = 1'b0;
      pc_w       = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      link_w     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 1'b0;
      result_src = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_w       = mem_ready;
            pc_w       = mem_ready;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR: alu_src_b = (funct_5 && funct_0) ? 2'b00 : 2'b01;
         S_MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECR: alu_op = 1'b1;
         S_EXECI: begin
            alu_op    = 1'b1;
            alu_src_b = 2'b01;
         end
         S_ALUWB: reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
`ifdef MAIN_FSM_BL_EN
            link_w     = link;
`endif
         end
         default: ;
      endcase
      if (reset) begin
         mem_req = 1'b0;
         ir_w    = 1'b0;
         pc_w    = 1'b0;
         branch  = 1'b0;
         reg_w   = 1'b0;
         mem_w   = 1'b0;
         link_w  = 1'b0;
      end
   end

   // Instruction-field decodes, independent of state.
   always_comb begin
      imm_src = op;
      if (op == 2'b10)
         reg_src = 2'b01;
      else if (op == 2'b01 && !funct_0)
         reg_src = 2'b10;
      else
         reg_src = 2'b00;
   end

   assign fault = (state_q == S_FAULT);
   assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed bench for main_fsm with a phase-plan model.
// The model expands each decoded instruction into its list of phases and
// checks every DUT output on every falling edge; directed runs also pin
// state traces and enable counts to hand-written literals.
module tb_main_fsm;

   localparam int WL = 4;
   localparam int CW = 4;

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_MEMADR = 2;
   localparam int P_MEMRD  = 3;
   localparam int P_MEMWB  = 4;
   localparam int P_MEMWR  = 5;
   localparam int P_EXECR  = 6;
   localparam int P_EXECI  = 7;
   localparam int P_ALUWB  = 8;
   localparam int P_BRANCH = 9;
   localparam int P_FAULT  = 10;

`ifdef MAIN_FSM_BL_EN
   localparam int BL_EN = 1;
`else
   localparam int BL_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] op = 2'b00;
   logic       funct_5 = 1'b0, funct_0 = 1'b0, link = 1'b0, mem_ready = 1'b0;
   logic       mem_req, adr_src, ir_w, pc_w, branch, reg_w, mem_w, link_w;
   logic       alu_src_a, alu_op, fault;
   logic [1:0] alu_src_b, result_src, imm_src, reg_src;
   logic [3:0] state;

   always #5 clk = ~clk;

   main_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .op(op), .funct_5(funct_5), .funct_0(funct_0),
      .link(link), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
      .ir_w(ir_w), .pc_w(pc_w), .branch(branch), .reg_w(reg_w), .mem_w(mem_w),
      .link_w(link_w), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
      .fault(fault), .state(state)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // ---------------- behavioural model: phase plan per instruction -----
   int  m_phase = P_FETCH;
   int  m_wait  = 0;
   int  m_plan[$];
   bit  m_valid = 1'b0;

   function automatic bit is_mem_phase(input int p);
      return (p == P_FETCH) || (p == P_MEMRD) || (p == P_MEMWR);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_phase = P_FETCH;
         m_wait  = 0;
         m_plan.delete();
         m_valid = 1'b1;
      end else if (m_valid && m_phase != P_FAULT) begin
         if (is_mem_phase(m_phase) && !mem_ready) begin
            if (WL > 0 && m_wait == WL) begin
               m_phase = P_FAULT;
               m_wait  = 0;
            end else if (m_wait < (1 << CW) - 1) begin
               m_wait++;
            end
         end else begin
            m_wait = 0;
            if (m_phase == P_FETCH) begin
               m_phase = P_DECODE;
            end else begin
               if (m_phase == P_DECODE) begin
                  m_plan.delete();
                  if (op == 2'b00) begin
                     m_plan.push_back(funct_5 ? P_EXECI : P_EXECR);
                     m_plan.push_back(P_ALUWB);
                  end else if (op == 2'b01) begin
                     m_plan.push_back(P_MEMADR);
                     if (funct_0) begin
                        m_plan.push_back(P_MEMRD);
                        m_plan.push_back(P_MEMWB);
                     end else begin
                        m_plan.push_back(P_MEMWR);
                     end
                  end else if (op == 2'b10) begin
                     m_plan.push_back(P_BRANCH);
                  end else begin
                     m_plan.push_back(P_FAULT);
                  end
               end
               if (m_plan.size() == 0) m_phase = P_FETCH;
               else m_phase = m_plan.pop_front();
            end
         end
      end
   end

   int e_req, e_adr, e_irw, e_pcw, e_br, e_regw, e_memw, e_lw;
   int e_a, e_b, e_aop, e_rs, e_flt, e_rsrc;

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         e_req = 0; e_adr = 0; e_irw = 0; e_pcw = 0; e_br = 0; e_regw = 0;
         e_memw = 0; e_lw = 0; e_a = 0; e_b = 0; e_aop = 0; e_rs = 0; e_flt = 0;
         case (m_phase)
            P_FETCH:  begin e_req = 1; e_a = 1; e_b = 2; e_rs = 2; e_irw = mem_ready; e_pcw = mem_ready; end
            P_DECODE: begin e_a = 1; e_b = 2; e_rs = 2; end
            P_MEMADR: e_b = (funct_5 && funct_0) ? 0 : 1;
            P_MEMRD:  begin e_req = 1; e_adr = 1; end
            P_MEMWB:  begin e_rs = 1; e_regw = 1; end
            P_MEMWR:  begin e_req = 1; e_adr = 1; e_memw = 1; end
            P_EXECR:  e_aop = 1;
            P_EXECI:  begin e_aop = 1; e_b = 1; end
            P_ALUWB:  e_regw = 1;
            P_BRANCH: begin e_b = 1; e_rs = 2; e_br = 1; e_lw = BL_EN & int'(link); end
            default:  e_flt = 1;
         endcase
         if (reset) begin
            e_req = 0; e_irw = 0; e_pcw = 0; e_br = 0; e_regw = 0; e_memw = 0; e_lw = 0;
         end
         e_rsrc = (op == 2'b10) ? 1 : ((op == 2'b01 && !funct_0) ? 2 : 0);
         chk("state", state, m_phase);
         chk("mem_req", mem_req, e_req);
         chk("adr_src", adr_src, e_adr);
         chk("ir_w", ir_w, e_irw);
         chk("pc_w", pc_w, e_pcw);
         chk("branch", branch, e_br);
         chk("reg_w", reg_w, e_regw);
         chk("mem_w", mem_w, e_memw);
         chk("link_w", link_w, e_lw);
         chk("alu_src_a", alu_src_a, e_a);
         chk("alu_src_b", alu_src_b, e_b);
         chk("alu_op", alu_op, e_aop);
         chk("result_src", result_src, e_rs);
         chk("imm_src", imm_src, op);
         chk("reg_src", reg_src, e_rsrc);
         chk("fault", fault, e_flt);
      end
   end

   // Cumulative enable counters and last BRANCH-cycle observation.
   int n_regw = 0, n_memw = 0, n_irw = 0;
   logic seen_br = 1'b0, seen_lw = 1'b0;
   always @(negedge clk) begin
      if (reg_w === 1'b1) n_regw++;
      if (mem_w === 1'b1) n_memw++;
      if (ir_w === 1'b1)  n_irw++;
      if (state == 4'(P_BRANCH)) begin
         seen_br = branch;
         seen_lw = link_w;
      end
   end

   // Drive one instruction; mem_ready per cycle comes from rdy_mask bit c.
   // Enters and leaves just after a rising edge; the last trace entry is
   // the state after the final edge.
   task automatic run_instr(input string nm, input logic [1:0] o, input logic i5,
                            input logic i0, input logic lk, input logic [31:0] rdy_mask,
                            input int len, input logic [63:0] exp_seq);
      logic [63:0] got;
      got = '0;
      op = o; funct_5 = i5; funct_0 = i0; link = lk;
      for (int c = 0; c < len - 1; c++) begin
         mem_ready = rdy_mask[c];
         @(negedge clk);
         got = {got[59:0], state};
         @(posedge clk);
         #1;
      end
      got = {got[59:0], state};
      $display("%s: state trace %0h expected %0h", nm, got, exp_seq);
      chk({nm, " trace"}, got, exp_seq);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
      end
      chk("reset state", state, 0);
      chk("reset fault", fault, 0);
      chk("reset mem_req", mem_req, 0);
      reset = 1'b0;
      $display("reset: %0d cycles, state %0d fault %0d", cycles, state, fault);
   endtask

   int r0, m0, i0;

   initial begin
      do_reset(2);

      r0 = n_regw; i0 = n_irw;
      run_instr("ADD reg", 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5, 64'h01680);
      chk("ADD reg_w count", n_regw - r0, 1);
      chk("ADD ir_w count", n_irw - i0, 1);

      run_instr("ADD imm", 2'b00, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 5, 64'h01780);

      r0 = n_regw;
      run_instr("LDR imm 3 stalls", 2'b01, 1'b0, 1'b1, 1'b0, ~32'h38, 9, 64'h012333340);
      chk("LDR reg_w count", n_regw - r0, 1);

      run_instr("LDR reg fetch stall", 2'b01, 1'b1, 1'b1, 1'b0, ~32'h3, 8, 64'h00012340);

      r0 = n_regw; m0 = n_memw;
      run_instr("STR 1 stall", 2'b01, 1'b0, 1'b0, 1'b0, ~32'h8, 6, 64'h012550);
      chk("STR mem_w count", n_memw - m0, 2);
      chk("STR reg_w count", n_regw - r0, 0);

      run_instr("B", 2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4, 64'h0190);
      chk("B branch", seen_br, 1);
      chk("B link_w", seen_lw, 0);

      run_instr("BL", 2'b10, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4, 64'h0190);
      chk("BL branch", seen_br, 1);
      chk("BL link_w", seen_lw, BL_EN);

      run_instr("LDR 4 stalls at limit", 2'b01, 1'b0, 1'b1, 1'b0, ~32'h78, 10, 64'h0123333340);

      run_instr("LDR 5 stalls timeout", 2'b01, 1'b0, 1'b1, 1'b0, ~32'hF8, 9, 64'h01233333A);
      mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("fault sticky", fault, 1);
         @(posedge clk);
         #1;
      end
      do_reset(1);

      run_instr("FETCH stall timeout", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 6, 64'h00000A);
      do_reset(1);

      run_instr("op 11", 2'b11, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 3, 64'h01A);
      do_reset(1);

      // STR stalled in MEMWR, then reset arrives while the write is pending.
      run_instr("STR to MEMWR", 2'b01, 1'b0, 1'b0, 1'b0, 32'h7, 4, 64'h0125);
      mem_ready = 1'b0;
      chk("MEMWR mem_w", mem_w, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("reset in MEMWR mem_w", mem_w, 0);
      chk("reset in MEMWR mem_req", mem_req, 0);
      @(posedge clk);
      #1;
      chk("reset in MEMWR next state", state, 0);
      reset = 1'b0;
      $display("reset during MEMWR: state %0d", state);

      run_instr("ADD after reset", 2'b00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5, 64'h01680);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
